// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer_pkg
//  Description : Shared frame geometry and state encoding for the final
//                fully-connected layer and its argmax classifier stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package layer_pkg;

    localparam int T  = 16;
    localparam int M  = 4;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/layer_argmax_if.sv
`default_nettype none
// ============================================================================
//  Module      : layer_argmax_if
//  Description : Activation stream in / classification result out bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface layer_argmax_if;
    import layer_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [T-1:0]  data_in;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] idx_out;
    logic [T-1:0]  max_out;

    // Block-side view: consumes activations, produces results
    modport slave (
        input  s_valid,
        input  data_in,
        input  m_ready,
        output s_ready,
        output m_valid,
        output idx_out,
        output max_out
    );

    modport master (
        output s_valid,
        output data_in,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  idx_out,
        input  max_out
    );

endinterface
`default_nettype wire

// File: rtl/layer_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : layer_argmax
//  Description : Tracks the signed running maximum over M activations per
//                frame and emits the winning index/value once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_argmax
    import layer_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    layer_argmax_if.slave bus
);

    localparam logic [IW-1:0] c_LAST = IW'(M - 1);

    state_t               r_state,     w_state_nxt;
    logic [IW-1:0]        r_cnt,       w_cnt_nxt;
    logic signed [T-1:0]  r_run_max,   w_run_max_nxt;
    logic [IW-1:0]        r_run_idx,   w_run_idx_nxt;
    logic [IW-1:0]        r_idx_out,   w_idx_out_nxt;
    logic signed [T-1:0]  r_max_out,   w_max_out_nxt;
    logic                 r_s_ready,   w_s_ready_nxt;
    logic                 r_m_valid,   w_m_valid_nxt;

    logic                 w_accept;
    logic signed [T-1:0]  w_din;
    logic                 w_gt;
    logic                 w_take;
    logic signed [T-1:0]  w_cand_max;
    logic [IW-1:0]        w_cand_idx;

    assign w_din    = $signed(bus.data_in);
    assign w_accept = bus.s_valid && r_s_ready && (r_state == COLLECT);
    assign w_gt     = (w_din > r_run_max);

    // Element 0 always seeds; later elements win only on a strict increase,
    // so ties keep the lower index. At cnt==0 the seed index equals r_cnt.
    assign w_take     = (r_cnt == '0) || w_gt;
    assign w_cand_max = w_take ? w_din : r_run_max;
    assign w_cand_idx = w_take ? r_cnt : r_run_idx;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_run_max_nxt = r_run_max;
        w_run_idx_nxt = r_run_idx;
        w_idx_out_nxt = r_idx_out;
        w_max_out_nxt = r_max_out;
        w_s_ready_nxt = r_s_ready;
        w_m_valid_nxt = r_m_valid;
        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    w_run_max_nxt = w_cand_max;
                    w_run_idx_nxt = w_cand_idx;
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt     = '0;
                        w_idx_out_nxt = w_cand_idx;
                        w_max_out_nxt = w_cand_max;
                        w_state_nxt   = EMIT;
                        w_s_ready_nxt = 1'b0;
                        w_m_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    w_state_nxt   = COLLECT;
                    w_s_ready_nxt = 1'b1;
                    w_m_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = COLLECT;
                w_s_ready_nxt = 1'b1;
                w_m_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_idx_out <= '0;
            r_max_out <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_run_max <= w_run_max_nxt;
            r_run_idx <= w_run_idx_nxt;
            r_idx_out <= w_idx_out_nxt;
            r_max_out <= w_max_out_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.idx_out = r_idx_out;
    assign bus.max_out = r_max_out;

endmodule
`default_nettype wire

// File: tb/tb_layer_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_argmax
//  Description : Directed self-checking bench for the argmax classifier stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_argmax;
    import layer_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    layer_argmax_if bus ();

    layer_argmax dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [T-1:0] obs, input logic [T-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; the block must be ready and idle on the result side
    task automatic beat(input logic [T-1:0] v);
        chk("s_ready_before_beat", T'(bus.s_ready), T'(1));
        chk("m_valid_before_beat", T'(bus.m_valid), T'(0));
        bus.s_valid = 1'b1;
        bus.data_in = v;
        tick();
    endtask

    task automatic check_result(input string tag, input logic [IW-1:0] e_idx, input logic [T-1:0] e_max);
        chk({tag, "_m_valid"}, T'(bus.m_valid), T'(1));
        chk({tag, "_s_ready"}, T'(bus.s_ready), T'(0));
        chk({tag, "_idx"},     T'(bus.idx_out), T'(e_idx));
        chk({tag, "_max"},     bus.max_out,     e_max);
    endtask

    task automatic frame(input string tag,
                         input logic [T-1:0] v0, input logic [T-1:0] v1,
                         input logic [T-1:0] v2, input logic [T-1:0] v3,
                         input logic [IW-1:0] e_idx, input logic [T-1:0] e_max);
        beat(v0);
        beat(v1);
        beat(v2);
        beat(v3);
        bus.s_valid = 1'b0;
        check_result(tag, e_idx, e_max);
        if (bus.m_ready) begin
            tick();
            chk({tag, "_bubble_m_valid"}, T'(bus.m_valid), T'(0));
            chk({tag, "_bubble_s_ready"}, T'(bus.s_ready), T'(1));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_s_ready"}, T'(bus.s_ready), T'(1));
        chk({tag, "_m_valid"}, T'(bus.m_valid), T'(0));
        chk({tag, "_idx"},     T'(bus.idx_out), T'(0));
        chk({tag, "_max"},     bus.max_out,     T'(0));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        frame("basic", 16'd10, 16'd40, 16'd25, 16'd3, 2'd1, 16'd40);
        frame("tie",   16'd7,  16'd30, 16'd30, 16'd5, 2'd1, 16'd30);
        frame("zeros", 16'd0,  16'd0,  16'd0,  16'd0, 2'd0, 16'd0);
        frame("neg",   16'h8000, 16'hFFFB, 16'h8001, 16'hFFFA, 2'd1, 16'hFFFB);
        frame("pos",   16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0000, 2'd0, 16'h7FFF);

        // Backpressure: result must hold while a competing beat is offered
        bus.m_ready = 1'b0;
        frame("bp", 16'd1, 16'd2, 16'd3, 16'd4, 2'd3, 16'd4);
        bus.s_valid = 1'b1;
        bus.data_in = 16'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_result("bp_hold", 2'd3, 16'd4);
        end
        bus.m_ready = 1'b1;
        tick();
        chk("bp_release_m_valid", T'(bus.m_valid), T'(0));
        chk("bp_release_s_ready", T'(bus.s_ready), T'(1));
        frame("after_bp", 16'd99, 16'd5, 16'd6, 16'd7, 2'd0, 16'd99);

        // Gapped beats with a large value on the idle cycles that must be ignored
        beat(16'd50);
        bus.s_valid = 1'b0; bus.data_in = 16'h7FFF; tick();
        beat(16'd60);
        bus.s_valid = 1'b0; bus.data_in = 16'h7FFF; tick();
        beat(16'd55);
        bus.s_valid = 1'b0; bus.data_in = 16'h7FFF; tick();
        chk("gap_no_early_result", T'(bus.m_valid), T'(0));
        beat(16'd70);
        bus.s_valid = 1'b0;
        check_result("gap", 2'd3, 16'd70);
        tick();
        chk("gap_release_s_ready", T'(bus.s_ready), T'(1));

        // Reset in the middle of a frame
        beat(16'd100);
        beat(16'd200);
        bus.s_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_mid");
        frame("post_rst_mid", 16'd9, 16'd8, 16'd7, 16'd6, 2'd0, 16'd9);

        // Reset with a result pending
        bus.m_ready = 1'b0;
        frame("pend", 16'd50, 16'd1, 16'd2, 16'd3, 2'd0, 16'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_emit");
        bus.m_ready = 1'b1;
        frame("post_rst_emit", 16'd9, 16'd8, 16'd7, 16'd6, 2'd0, 16'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
